io_bus_master: RTL
==================

Name: io_bus_master

Overview:
Initiator for the register-port bus: enable / write / ready / data.
- Accepts one command at a time from a host-side valid/ready command port.
- Decodes the address to a one-hot slave enable and drives write and write data.
- Waits for the addressed slave's ready, captures read data, and returns a response.
- Converts missing ready (timeout) and out-of-range addresses into error responses.
- Sits between the control core and the bank of io_register slaves.

Parameters:
DATA_WIDTH, 32, width of bus and command data.
NUM_SLAVES, 4, number of slave enable lines; valid addresses are 0..NUM_SLAVES-1.
ADDR_WIDTH, 4, command address width; must satisfy 2**ADDR_WIDTH >= NUM_SLAVES.
TIMEOUT_CYCLES, 16, maximum number of ACCESS cycles without ready before an error response (>=2).

Ports:
clk_in  input  1  clock, all logic on rising edge.
rst_in  input  1  synchronous, active-high reset.
cmd_valid  input  1  host command valid.
cmd_ready  output  1  master can accept a command.
cmd_write  input  1  1 = write, 0 = read.
cmd_addr  input  ADDR_WIDTH  slave index.
cmd_wdata  input  DATA_WIDTH  write data.
rsp_valid  output  1  response valid.
rsp_ready  input  1  host consumes response.
rsp_rdata  output  DATA_WIDTH  data captured from slave.
rsp_error  output  1  timeout or bad address.
bus_enable  output  NUM_SLAVES  one-hot slave enable.
bus_write  output  1  write strobe to slaves.
bus_wdata  output  DATA_WIDTH  data to slaves.
bus_ready  input  1  shared slave ready; may float (z) when no slave is enabled.
bus_rdata  input  DATA_WIDTH  shared slave read data; may be z.

Behaviour:
- Reset: synchronous, active-high, wins over everything; takes effect at the next edge.
  - State becomes IDLE.
  - Outputs after reset: cmd_ready=1, rsp_valid=0, rsp_error=0, rsp_rdata=0, bus_enable=0, bus_write=0, bus_wdata=0.
  - Timeout counter cleared.
  - Any in-flight transaction is dropped with no response.
- Ready detection: ready is recognised only when bus_ready is exactly 1'b1. Values z, x and 0 all mean not ready.
- IDLE:
  - cmd_ready=1.
  - On an edge with cmd_valid=1, the command is latched and cmd_ready drops.
  - If cmd_addr >= NUM_SLAVES, go to RESP with rsp_error=1, rsp_rdata=0 and no bus activity.
  - Otherwise go to ACCESS.
- ACCESS:
  - bus_enable = one-hot(addr); bus_write = latched write flag; bus_wdata = latched data. All are registered and stable for the whole state.
  - Counter increments each cycle.
  - First cycle with bus_ready===1: rsp_rdata <= bus_rdata, rsp_error <= 0, go to RESP. The enable and write outputs clear on that same edge.
  - If the counter reaches TIMEOUT_CYCLES without ready: rsp_error <= 1, rsp_rdata <= 0, drive the bus lines to 0, go to RESP.
  - Ready in the same cycle the timeout expires: ready wins, no error.
- RESP:
  - rsp_valid=1, with rsp_rdata and rsp_error held stable.
  - bus_enable=0, cmd_ready=0.
  - On an edge with rsp_ready=1, go to IDLE and clear rsp_valid.
  - No new command is accepted in the same cycle (minimum 1 IDLE cycle between transactions).
- Latency (io_register slave): accept edge E0; enable high in cycles E0..E2; ready seen in cycle E1+1; rsp_valid high from E3.
  - Because the slave is sampled on two enabled edges, a write is written twice with identical data; this is harmless.
- Write responses: rsp_rdata carries whatever the slave returned with ready. An io_register returns its pre-write contents.
- Only one transaction is outstanding at a time; cmd_* inputs are ignored outside IDLE.

Test Plan:
- Reset with rst_in=1 for 2 cycles → cmd_ready=1, rsp_valid=0, bus_enable=0, bus_write=0, bus_wdata=0.
- Write addr 1, data 0xDEADBEEF, then read addr 1:
  - Write: bus_enable=4'b0010 with bus_write=1, rsp_error=0.
  - Read: rsp_rdata=0xDEADBEEF, bus_write=0 during the read.
- Write 0x12345678 to addr 2 when it holds 0xDEADBEEF → rsp_rdata=0xDEADBEEF (old value); a following read of addr 2 returns 0x12345678.
- Read addr 3 with no slave attached (bus_ready=z):
  - rsp_error=1 and rsp_rdata=0 after exactly TIMEOUT_CYCLES=16 ACCESS cycles.
  - bus_enable returns to 0.
- Command addr 7 with NUM_SLAVES=4 → rsp_valid one cycle after accept, rsp_error=1, bus_enable never asserted.
- Assert rst_in during ACCESS → next cycle bus_enable=0, state IDLE, no rsp_valid.
- Hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata held stable, cmd_ready=0 throughout.

Source files
------------

// File: rtl/io_bus_master.sv
// Register-port bus initiator: one command in flight, one-hot slave
// enable, ready wait with timeout, error response for bad addresses.
module io_bus_master #(
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_SLAVES     = 4,
   parameter int ADDR_WIDTH     = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_error,
   output logic [NUM_SLAVES-1:0] bus_enable,
   output logic                  bus_write,
   output logic [DATA_WIDTH-1:0] bus_wdata,
   input  logic                  bus_ready,
   input  logic [DATA_WIDTH-1:0] bus_rdata
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_RESP
   } state_t;

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   state_t                r_state;
   logic [CW-1:0]         r_cnt;
   logic                  w_ready;
   logic                  w_bad;
   logic [NUM_SLAVES-1:0] w_onehot;

   // A floating or unknown ready line never counts as ready
   assign w_ready  = (bus_ready === 1'b1);
   assign w_bad    = 32'(cmd_addr) >= 32'(NUM_SLAVES);
   assign w_onehot = NUM_SLAVES'(1) << cmd_addr;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         cmd_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_error  <= 1'b0;
         rsp_rdata  <= '0;
         bus_enable <= '0;
         bus_write  <= 1'b0;
         bus_wdata  <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  cmd_ready <= 1'b0;
                  if (w_bad) begin
                     rsp_error <= 1'b1;
                     rsp_rdata <= '0;
                     rsp_valid <= 1'b1;
                     r_state   <= S_RESP;
                  end else begin
                     bus_enable <= w_onehot;
                     bus_write  <= cmd_write;
                     bus_wdata  <= cmd_wdata;
                     r_cnt      <= '0;
                     r_state    <= S_ACCESS;
                  end
               end
            end
            S_ACCESS: begin
               // Ready is tested first so it wins on the expiry cycle
               if (w_ready) begin
                  rsp_rdata  <= bus_rdata;
                  rsp_error  <= 1'b0;
                  rsp_valid  <= 1'b1;
                  bus_enable <= '0;
                  bus_write  <= 1'b0;
                  bus_wdata  <= '0;
                  r_state    <= S_RESP;
               end else if (r_cnt == LAST) begin
                  rsp_rdata  <= '0;
                  rsp_error  <= 1'b1;
                  rsp_valid  <= 1'b1;
                  bus_enable <= '0;
                  bus_write  <= 1'b0;
                  bus_wdata  <= '0;
                  r_state    <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  r_state   <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
